sawtooth_arbiter: RTL and testbench
===================================

Name: sawtooth_arbiter

Overview:
- Shares one pipelined sawtooth unit (fixed latency, one input per cycle, in-order results, no stall) among NUM_REQ chaotic-map requesters, e.g. per-channel keystream generators.
- Grants one request per cycle, round-robin, and records each requester ID in an in-order tag FIFO.
- Routes each returned result to its originator using that FIFO, so the sawtooth unit needs no tag sideband.
- Sits between the keystream generators and the sawtooth instance.

Parameters:
- PRECISION, 32, float word width of x, epsilon and result.
- NUM_REQ, 4, number of requesters, 2..8.
- TAG_DEPTH, 64, max in-flight operations; must be >= sawtooth latency for full throughput; power of 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero.
- req_x  in  NUM_REQ*PRECISION  packed x operands; requester i at slice [i*PRECISION +: PRECISION].
- req_eps  in  NUM_REQ*PRECISION  packed epsilon operands, same packing.
- st_tvalid  out  1  issue strobe to sawtooth unit.
- st_x  out  PRECISION  x to sawtooth unit.
- st_eps  out  PRECISION  epsilon to sawtooth unit.
- st_valid  in  1  result valid from sawtooth unit.
- st_result  in  PRECISION  result from sawtooth unit.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  PRECISION  response data, shared by all requesters.
- outstanding  out  $clog2(TAG_DEPTH)+1  in-flight count.
- err_orphan  out  1  sticky: a result arrived with no tag.

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk. Under reset all registered outputs clear: st_tvalid=0, st_x=0, st_eps=0, rsp_valid=0, rsp_data=0, outstanding=0, err_orphan=0. Tag FIFO is emptied; RR pointer = NUM_REQ-1, so requester 0 has priority first.
- Arbitration is combinational.
  - can_issue = (outstanding < TAG_DEPTH), using the registered count; a pop in the same cycle gives no bypass.
  - With can_issue high, the winner is the first i with req_valid[i], searching from ptr+1 upward with wrap. req_ready[winner]=1; all other bits are 0.
  - With can_issue low, req_ready = 0.
  - req_ready may depend on req_valid. A requester must hold req_valid and its operands stable until it sees ready.
- Issue, at accept cycle t: st_x, st_eps and st_tvalid are registered at t+1. The tag FIFO pushes the winner index at t+1. ptr <= winner.
- No accept at t: st_tvalid=0 at t+1; st_x and st_eps hold their previous values.
- Return, with st_valid at cycle r:
  - Pop the FIFO head h. At r+1: rsp_valid = one-hot(h), rsp_data = st_result.
  - No st_valid: rsp_valid=0 and rsp_data holds.
  - Requesters have no backpressure; they must sink rsp_valid.
- Orphan: st_valid while the FIFO is empty sets err_orphan=1 (sticky until reset). No rsp_valid, no pop, outstanding unchanged.
- outstanding tracks in-flight operations:
  - +1 on accept; -1 on a valid pop; accept and pop in the same cycle leave it unchanged.
  - Never exceeds TAG_DEPTH; never underflows.
- FIFO push and pop in the same cycle are both legal at any occupancy below full, including empty (push then pop order preserved).
- Throughput: one issue per cycle sustained while outstanding < TAG_DEPTH.
- Reset mid-operation: in-flight results returning after reset release see an empty FIFO and raise err_orphan. Upstream must reset the sawtooth unit together with this block.

Decomposition:
- Package sawtooth_pkg holds:
  - FP_ONE = 32'h3F800000.
  - Function ID_W(NUM_REQ) = $clog2(NUM_REQ), min 1.
  - Function CNT_W(TAG_DEPTH).
  - Packed-slice helper macro/function for operand buses.
- One sub-module, sawtooth_tag_fifo: synchronous FIFO of ID_W-bit entries, depth TAG_DEPTH, with push/pop/full/empty, simultaneous push+pop, and async active-low reset.
- Arbiter, issue registers and response routing stay in sawtooth_arbiter.

Test Plan:
- Single request: req_valid=4'b0001, req_x=0x3F000000, req_eps=0x3F800000 -> req_ready=0001 the same cycle; next cycle st_tvalid=1 with st_x=0x3F000000. Model returns 0x3F000000 at latency L -> rsp_valid=0001 and rsp_data=0x3F000000 at L+1 after issue; outstanding goes 0→1→0.
- All four requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Results tagged per requester (e.g. result = 0x40000000+i) come back in order, each to the matching rsp_valid bit.
- Fairness with a gap: req 1 and 3 valid, ptr=1 -> grant 3, then 1, then 3. Requester 2 raises valid mid-stream -> granted within NUM_REQ cycles.
- Full: TAG_DEPTH=4 and the model withholds results -> after 4 accepts req_ready=0 with outstanding=4. One st_valid pops -> outstanding goes 4→3 and grants resume the cycle after. Accept and pop in the same cycle -> count unchanged.
- Orphan: st_valid=1 with an empty FIFO -> err_orphan=1, rsp_valid=0, outstanding=0. err_orphan stays 1 until reset_n is pulsed low.
- Async reset asserted mid-burst, 3 in flight -> outputs clear immediately without a clock edge. After release, a first request from req 0 is granted and ptr behaviour restarts from req 0.

Source files
------------

// File: rtl/sawtooth_pkg.sv
// Shared constants and width helpers for the sawtooth arbiter slice.
package sawtooth_pkg;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  function automatic int ID_W(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int CNT_W(input int tag_depth);
    return $clog2(tag_depth) + 1;
  endfunction

  // LSB of element idx in a packed bus of width-bit elements.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sawtooth_tag_fifo.sv
// In-order tag FIFO holding requester IDs for operations in flight.
module sawtooth_tag_fifo
  import sawtooth_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [CNT_W(DEPTH)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = CNT_W(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  // An empty FIFO may still pop the entry being pushed this cycle.
  assign do_pop  = pop && (!empty || do_push);
  assign pop_data = empty ? push_data : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sawtooth_arbiter.sv
// Round-robin sharing of one pipelined sawtooth unit; results are routed
// back to their requesters through an in-order tag FIFO.
module sawtooth_arbiter
  import sawtooth_pkg::*;
#(
  parameter int PRECISION = 32,
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*PRECISION-1:0]   req_x,
  input  logic [NUM_REQ*PRECISION-1:0]   req_eps,
  output logic                           st_tvalid,
  output logic [PRECISION-1:0]           st_x,
  output logic [PRECISION-1:0]           st_eps,
  input  logic                           st_valid,
  input  logic [PRECISION-1:0]           st_result,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [PRECISION-1:0]           rsp_data,
  output logic [CNT_W(TAG_DEPTH)-1:0]    outstanding,
  output logic                           err_orphan
);

  localparam int IW = ID_W(NUM_REQ);

  logic [IW-1:0]        ptr;
  logic [IW-1:0]        win_id;
  logic                 found;
  logic                 accept;
  logic                 can_issue;
  logic [PRECISION-1:0] x_sel;
  logic [PRECISION-1:0] eps_sel;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [IW-1:0]        fifo_head;
  logic                 pop;
  logic                 orphan_hit;

  assign can_issue = !fifo_full;

  // First valid requester strictly after the last winner, wrapping.
  always_comb begin
    int idx;
    logic [IW-1:0] cand;
    found  = 1'b0;
    win_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(ptr) + k) % NUM_REQ;
      cand = IW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
    accept    = found && can_issue;
    req_ready = accept ? (NUM_REQ'(1) << win_id) : '0;
  end

  always_comb begin
    x_sel   = '0;
    eps_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == IW'(i)) begin
        x_sel   = req_x[slice_lsb(i, PRECISION) +: PRECISION];
        eps_sel = req_eps[slice_lsb(i, PRECISION) +: PRECISION];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_tvalid <= 1'b0;
      st_x      <= '0;
      st_eps    <= '0;
      ptr       <= IW'(NUM_REQ - 1);
    end else begin
      st_tvalid <= accept;
      if (accept) begin
        st_x   <= x_sel;
        st_eps <= eps_sel;
        ptr    <= win_id;
      end
    end
  end

  sawtooth_tag_fifo #(
    .WIDTH (IW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (win_id),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  // A result with no recorded tag cannot be routed; flag it and drop it.
  assign pop        = st_valid && !fifo_empty;
  assign orphan_hit = st_valid && fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= pop ? (NUM_REQ'(1) << fifo_head) : '0;
      if (pop)        rsp_data   <= st_result;
      if (orphan_hit) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sawtooth_arbiter.sv
// Directed bench for sawtooth_arbiter with a queue-based reference model
// and a fixed-latency sawtooth unit stand-in that echoes st_x.
module tb_sawtooth_arbiter;
  import sawtooth_pkg::*;

  localparam int P   = 32;
  localparam int NR  = 4;
  localparam int TD  = 4;
  localparam int L   = 2;
  localparam int CW  = CNT_W(TD);
  localparam int BIG = 1000000;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*P-1:0] req_x;
  logic [NR*P-1:0] req_eps;
  logic            st_tvalid;
  logic [P-1:0]    st_x;
  logic [P-1:0]    st_eps;
  logic            st_valid;
  logic [P-1:0]    st_result;
  logic [NR-1:0]   rsp_valid;
  logic [P-1:0]    rsp_data;
  logic [CW-1:0]   outstanding;
  logic            err_orphan;

  always #5 clk = ~clk;

  sawtooth_arbiter #(.PRECISION(P), .NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_eps     (req_eps),
    .st_tvalid   (st_tvalid),
    .st_x        (st_x),
    .st_eps      (st_eps),
    .st_valid    (st_valid),
    .st_result   (st_result),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int            m_last;
  int            m_tags[$];
  logic          exp_st_tvalid;
  logic [P-1:0]  exp_st_x, exp_st_eps, exp_rsp_data;
  logic [NR-1:0] exp_rsp_valid;
  logic          exp_orphan;

  // observation logs
  int           dut_grants[$];
  int           rsp_id[$];
  logic [P-1:0] rsp_dat[$];

  // sawtooth unit stand-in
  logic [P-1:0] pipe_d[$];
  int           pipe_t[$];
  int           rel_budget;
  int           cyc;
  logic         inject;
  logic [P-1:0] inj_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_id(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = NR - 1;
    m_tags.delete();
    exp_st_tvalid = 1'b0;
    exp_st_x      = '0;
    exp_st_eps    = '0;
    exp_rsp_valid = '0;
    exp_rsp_data  = '0;
    exp_orphan    = 1'b0;
    pipe_d.delete();
    pipe_t.delete();
  endtask

  task automatic check_cycle();
    int win;
    logic [NR-1:0] exp_ready;
    win = -1;
    exp_ready = '0;
    if (m_tags.size() < TD) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (win < 0 && req_valid[c]) win = c;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("req_ready",   req_ready,   exp_ready);
    chk("st_tvalid",   st_tvalid,   exp_st_tvalid);
    chk("st_x",        st_x,        exp_st_x);
    chk("st_eps",      st_eps,      exp_st_eps);
    chk("rsp_valid",   rsp_valid,   exp_rsp_valid);
    chk("rsp_data",    rsp_data,    exp_rsp_data);
    chk("outstanding", outstanding, m_tags.size());
    chk("err_orphan",  err_orphan,  exp_orphan);
    if (req_ready != '0) dut_grants.push_back(onehot_id(req_ready));
    if (rsp_valid != '0) begin
      rsp_id.push_back(onehot_id(rsp_valid));
      rsp_dat.push_back(rsp_data);
    end
    exp_rsp_valid = '0;
    if (st_valid) begin
      if (m_tags.size() > 0) begin
        exp_rsp_valid[m_tags[0]] = 1'b1;
        exp_rsp_data = st_result;
        void'(m_tags.pop_front());
      end else begin
        exp_orphan = 1'b1;
      end
    end
    exp_st_tvalid = (win >= 0);
    if (win >= 0) begin
      m_tags.push_back(win);
      m_last     = win;
      exp_st_x   = req_x[win*P +: P];
      exp_st_eps = req_eps[win*P +: P];
    end
  endtask

  // One clock cycle: drive the unit's return, check at negedge, end at posedge+1.
  task automatic tick();
    cyc++;
    if (inject) begin
      st_valid  = 1'b1;
      st_result = inj_data;
    end else if (rel_budget > 0 && pipe_t.size() > 0 && pipe_t[0] <= cyc) begin
      st_valid  = 1'b1;
      st_result = pipe_d.pop_front();
      void'(pipe_t.pop_front());
      rel_budget--;
    end else begin
      st_valid = 1'b0;
    end
    @(negedge clk);
    if (reset_n) check_cycle();
    if (st_tvalid === 1'b1) begin
      pipe_d.push_back(st_x);
      pipe_t.push_back(cyc + L);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    reset_n    = 1'b0;
    req_valid  = '0;
    req_x      = '0;
    req_eps    = '0;
    st_valid   = 1'b0;
    st_result  = '0;
    inject     = 1'b0;
    inj_data   = '0;
    rel_budget = BIG;
    cyc        = 0;
    model_reset();
    #2;
    chk("lit_rst_st_tvalid",   st_tvalid,   0);
    chk("lit_rst_outstanding", outstanding, 0);
    chk("lit_rst_rsp_valid",   rsp_valid,   0);
    chk("lit_rst_err_orphan",  err_orphan,  0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // all four requesters continuously valid
    for (int i = 0; i < NR; i++) begin
      req_x[i*P +: P]   = 32'h4000_0000 + i;
      req_eps[i*P +: P] = FP_ONE;
    end
    req_valid = 4'hF;
    repeat (8) tick();
    req_valid = '0;
    repeat (8) tick();
    chk("lit_grant_count", dut_grants.size(), 8);
    for (int k = 0; k < 8; k++)
      chk("lit_grant_order", (k < dut_grants.size()) ? dut_grants[k] : -1, k % 4);
    chk("lit_rsp_count", rsp_id.size(), 8);
    if (rsp_id.size() == 8) begin
      chk("lit_rsp0_id",   rsp_id[0],  0);
      chk("lit_rsp0_data", rsp_dat[0], 32'h4000_0000);
      chk("lit_rsp7_id",   rsp_id[7],  3);
      chk("lit_rsp7_data", rsp_dat[7], 32'h4000_0003);
    end

    // single request, latency L
    dut_grants.delete();
    req_x[0 +: P]   = 32'h3F00_0000;
    req_eps[0 +: P] = FP_ONE;
    req_valid = 4'b0001;
    #1;
    chk("lit_single_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("lit_single_tvalid", st_tvalid,   1);
    chk("lit_single_x",      st_x,        32'h3F00_0000);
    chk("lit_single_eps",    st_eps,      32'h3F80_0000);
    chk("lit_single_out1",   outstanding, 1);
    tick();
    chk("lit_single_norsp_a", rsp_valid, 0);
    tick();
    chk("lit_single_norsp_b", rsp_valid, 0);
    tick();
    chk("lit_single_rsp_valid", rsp_valid,   4'b0001);
    chk("lit_single_rsp_data",  rsp_data,    32'h3F00_0000);
    chk("lit_single_out0",      outstanding, 0);

    // fairness with a gap, then requester 2 joins
    dut_grants.delete();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    repeat (3) tick();
    req_valid = 4'b1110;
    repeat (4) tick();
    req_valid = '0;
    repeat (8) tick();
    chk("lit_fair_count", dut_grants.size(), 8);
    if (dut_grants.size() == 8) begin
      chk("lit_fair_g1", dut_grants[1], 3);
      chk("lit_fair_g2", dut_grants[2], 1);
      chk("lit_fair_g3", dut_grants[3], 3);
    end
    f = 1'b0;
    for (int k = 4; k < dut_grants.size() && k < 4 + NR; k++)
      if (dut_grants[k] == 2) f = 1'b1;
    chk("lit_req2_within", f, 1);

    // fill the tag FIFO with results withheld
    rel_budget = 0;
    req_valid  = 4'hF;
    repeat (4) tick();
    #1;
    chk("lit_full_out",   outstanding, 4);
    chk("lit_full_ready", req_ready,   0);
    tick();
    chk("lit_full_hold", outstanding, 4);
    rel_budget = 1;
    tick();
    #1;
    chk("lit_full_pop",    outstanding, 3);
    chk("lit_full_resume", req_ready,   4'b0100);
    rel_budget = 1;
    tick();
    chk("lit_full_push_pop", outstanding, 3);
    req_valid  = '0;
    rel_budget = BIG;
    repeat (10) tick();
    chk("lit_full_drain", outstanding, 0);

    // orphan result
    inject   = 1'b1;
    inj_data = 32'hDEAD_BEEF;
    tick();
    inject = 1'b0;
    chk("lit_orphan_flag", err_orphan,  1);
    chk("lit_orphan_rsp",  rsp_valid,   0);
    chk("lit_orphan_out",  outstanding, 0);
    repeat (5) tick();
    chk("lit_orphan_sticky", err_orphan, 1);

    // async reset with three operations in flight
    rel_budget = 0;
    req_valid  = 4'hF;
    repeat (3) tick();
    chk("lit_burst_out", outstanding, 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("lit_arst_tvalid",  st_tvalid,   0);
    chk("lit_arst_x",       st_x,        0);
    chk("lit_arst_eps",     st_eps,      0);
    chk("lit_arst_rsp",     rsp_valid,   0);
    chk("lit_arst_data",    rsp_data,    0);
    chk("lit_arst_out",     outstanding, 0);
    chk("lit_arst_orphan",  err_orphan,  0);
    chk("lit_arst_ready",   req_ready,   4'b0001);
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    reset_n    = 1'b1;
    rel_budget = BIG;
    req_valid  = 4'b0001;
    #1;
    chk("lit_post_ready0", req_ready, 4'b0001);
    tick();
    req_valid = 4'hF;
    #1;
    chk("lit_post_ready1", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    repeat (8) tick();
    chk("lit_post_drain", outstanding, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
